spi_master_pingpong: RTL and testbench

SPI mode-0 master that drives the far end of our SPI slave link. Each frame it streams FRAME_LEN bytes from the read port of a TX ping-pong RAM out on MOSI. At the same time it captures the same number of MISO bytes into the write port of an RX ping-pong RAM. It starts a frame only when the slave's DRDY and both local buffers are ready, and it signals buffer swap with one-cycle finish pulses.

---
 rtl/spi_master_pingpong.sv | 201 ++++++++++++++++++++
 tb/tb_spi_master_pingpong.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_pingpong.sv
// spi_master_pingpong: SPI mode-0 master that streams one frame of bytes from a
// TX ping-pong RAM out on MOSI while capturing the same number of MISO bytes
// into an RX ping-pong RAM. It signals buffer swap with one-cycle finish pulses.
module spi_master_pingpong #(
  parameter int CLK_DIV   = 2,
  parameter int FRAME_LEN = 128,
  parameter int ADDR_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drdy,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] tx_addr,
  input  logic [7:0]        tx_data,
  output logic              tx_finish,
  input  logic              rx_ready,
  output logic [ADDR_W-1:0] rx_addr,
  output logic [7:0]        rx_data,
  output logic              rx_we,
  output logic              rx_finish,
  output logic              sck,
  output logic              ssel,
  output logic              mosi,
  input  logic              miso,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [7:0]        DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, SHIFT, STORE, HOLD, DONE, GUARD
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        div_cnt_q, div_cnt_d;
  logic [6:0]        shift_tx_q, shift_tx_d;
  logic [7:0]        shift_rx_q, shift_rx_d;
  logic              sck_q, sck_d;
  logic              ssel_q, ssel_d;
  logic              mosi_q, mosi_d;
  logic [ADDR_W-1:0] tx_addr_q, tx_addr_d;
  logic [ADDR_W-1:0] rx_addr_q, rx_addr_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_we_q, rx_we_d;
  logic              finish_q, finish_d;
  logic              busy_q, busy_d;

  logic start;
  logic div_done;
  logic last_byte;

  assign start     = drdy & tx_ready & rx_ready;
  assign div_done  = (div_cnt_q == DIV_LAST);
  assign last_byte = (byte_cnt_q == LAST_BYTE);

  // State register plus all registered datapath and outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      sck_q      <= 1'b0;
      ssel_q     <= 1'b1;
      mosi_q     <= 1'b0;
      tx_addr_q  <= '0;
      rx_addr_q  <= '0;
      rx_data_q  <= '0;
      rx_we_q    <= 1'b0;
      finish_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      shift_tx_q <= shift_tx_d;
      shift_rx_q <= shift_rx_d;
      sck_q      <= sck_d;
      ssel_q     <= ssel_d;
      mosi_q     <= mosi_d;
      tx_addr_q  <= tx_addr_d;
      rx_addr_q  <= rx_addr_d;
      rx_data_q  <= rx_data_d;
      rx_we_q    <= rx_we_d;
      finish_q   <= finish_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic: frame sequencing, one byte at a time.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (div_done && sck_q && (bit_cnt_q == 3'd7)) state_d = STORE;
      STORE:   state_d = last_byte ? HOLD : FETCH;
      HOLD:    if (div_done) state_d = DONE;
      DONE:    state_d = GUARD;
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath logic: values that appear on the pins in the next state.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    sck_d      = sck_q;
    ssel_d     = ssel_q;
    mosi_d     = mosi_q;
    tx_addr_d  = tx_addr_q;
    rx_addr_d  = rx_addr_q;
    rx_data_d  = rx_data_q;
    rx_we_d    = 1'b0;
    finish_d   = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ssel_d     = 1'b0;
          busy_d     = 1'b1;
          byte_cnt_d = '0;
          tx_addr_d  = '0;
        end
      end
      FETCH: begin
        tx_addr_d = byte_cnt_q;
      end
      LOAD: begin
        shift_tx_d = tx_data[6:0];
        mosi_d     = tx_data[7];
        bit_cnt_d  = '0;
        div_cnt_d  = '0;
        sck_d      = 1'b0;
      end
      SHIFT: begin
        if (div_done) begin
          div_cnt_d = '0;
          sck_d     = ~sck_q;
          if (!sck_q) begin
            shift_rx_d = {shift_rx_q[6:0], miso};
          end else if (bit_cnt_q != 3'd7) begin
            bit_cnt_d  = bit_cnt_q + 3'd1;
            mosi_d     = shift_tx_q[6];
            shift_tx_d = {shift_tx_q[5:0], 1'b0};
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      STORE: begin
        rx_we_d   = 1'b1;
        rx_addr_d = byte_cnt_q;
        rx_data_d = shift_rx_q;
        div_cnt_d = '0;
        if (!last_byte) begin
          byte_cnt_d = byte_cnt_q + ADDR_W'(1);
          // The RAM read is registered, so the next address must already be
          // on tx_addr during FETCH for the data to be there in LOAD.
          tx_addr_d  = byte_cnt_q + ADDR_W'(1);
        end
      end
      HOLD: begin
        if (div_done) begin
          ssel_d   = 1'b1;
          busy_d   = 1'b0;
          finish_d = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign tx_addr    = tx_addr_q;
  assign rx_addr    = rx_addr_q;
  assign rx_data    = rx_data_q;
  assign rx_we      = rx_we_q;
  assign sck        = sck_q;
  assign ssel       = ssel_q;
  assign mosi       = mosi_q;
  assign busy       = busy_q;
  assign tx_finish  = finish_q;
  assign rx_finish  = finish_q;
  assign frame_done = finish_q;

endmodule

// File: tb/tb_spi_master_pingpong.sv
// tb_spi_master_pingpong: two instances (CLK_DIV=2 and CLK_DIV=3) driven with
// random RAM contents and MISO patterns; expectations come from frame-level rules.
module tb_spi_master_pingpong;

  localparam int DIV_A = 2, LEN_A = 4, AW_A = 3;
  localparam int DIV_B = 3, LEN_B = 3, AW_B = 3;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   passed = 0;

  // Free-running system clock
  always #5 clk = ~clk;

  // ---------------- DUT A ----------------
  logic            a_drdy, a_tx_ready, a_rx_ready, a_miso, a_loop, a_miso_drv;
  logic [AW_A-1:0] a_tx_addr, a_rx_addr;
  logic [7:0]      a_tx_data, a_rx_data;
  logic            a_tx_finish, a_rx_finish, a_rx_we, a_sck, a_ssel, a_mosi, a_busy, a_frame_done;
  logic [7:0]      a_mem [0:(1<<AW_A)-1];
  logic [7:0]      a_pat [0:LEN_A-1];

  assign a_miso = a_loop ? a_mosi : a_miso_drv;

  // Synchronous-read TX RAM model for DUT A
  always @(posedge clk) a_tx_data <= a_mem[a_tx_addr];

  spi_master_pingpong #(.CLK_DIV(DIV_A), .FRAME_LEN(LEN_A), .ADDR_W(AW_A)) dut_a (
    .clk(clk), .rst(rst), .drdy(a_drdy), .tx_ready(a_tx_ready), .tx_addr(a_tx_addr),
    .tx_data(a_tx_data), .tx_finish(a_tx_finish), .rx_ready(a_rx_ready), .rx_addr(a_rx_addr),
    .rx_data(a_rx_data), .rx_we(a_rx_we), .rx_finish(a_rx_finish), .sck(a_sck), .ssel(a_ssel),
    .mosi(a_mosi), .miso(a_miso), .busy(a_busy), .frame_done(a_frame_done)
  );

  // ---------------- DUT B ----------------
  logic            b_go, b_miso;
  logic [AW_B-1:0] b_tx_addr, b_rx_addr;
  logic [7:0]      b_tx_data, b_rx_data;
  logic            b_tx_finish, b_rx_finish, b_rx_we, b_sck, b_ssel, b_mosi, b_busy, b_frame_done;
  logic [7:0]      b_mem [0:(1<<AW_B)-1];

  assign b_miso = b_mosi;

  // Synchronous-read TX RAM model for DUT B
  always @(posedge clk) b_tx_data <= b_mem[b_tx_addr];

  spi_master_pingpong #(.CLK_DIV(DIV_B), .FRAME_LEN(LEN_B), .ADDR_W(AW_B)) dut_b (
    .clk(clk), .rst(rst), .drdy(b_go), .tx_ready(b_go), .tx_addr(b_tx_addr),
    .tx_data(b_tx_data), .tx_finish(b_tx_finish), .rx_ready(b_go), .rx_addr(b_rx_addr),
    .rx_data(b_rx_data), .rx_we(b_rx_we), .rx_finish(b_rx_finish), .sck(b_sck), .ssel(b_ssel),
    .mosi(b_mosi), .miso(b_miso), .busy(b_busy), .frame_done(b_frame_done)
  );

  // ---------------- frame observer for DUT A ----------------
  int         a_cyc, a_rises, a_first_rise, a_fall_cyc, a_rise_cyc, a_done_cyc, a_low;
  int         a_txf, a_rxf, a_fd;
  int         a_wr_addr[$];
  logic [7:0] a_wr_data[$];
  logic       a_sck_prev, a_ssel_prev;

  task automatic a_ready(input logic v);
    a_drdy = v; a_tx_ready = v; a_rx_ready = v;
  endtask

  task automatic a_clear();
    a_cyc = 0; a_rises = 0; a_first_rise = -1; a_fall_cyc = -1; a_rise_cyc = -1;
    a_done_cyc = -1; a_low = 0; a_txf = 0; a_rxf = 0; a_fd = 0;
    a_wr_addr.delete(); a_wr_data.delete();
    a_sck_prev = a_sck; a_ssel_prev = a_ssel;
    a_miso_drv = a_pat[0][7];
  endtask

  task automatic a_step();
    logic [7:0] pb;
    @(negedge clk);
    a_cyc++;
    if (a_sck && !a_sck_prev) begin
      a_rises++;
      if (a_first_rise < 0) a_first_rise = a_cyc;
      if (a_rises < 8*LEN_A) begin
        pb = a_pat[a_rises/8];
        a_miso_drv = pb[7 - (a_rises % 8)];
      end
    end
    if (!a_ssel && a_ssel_prev && a_fall_cyc < 0) a_fall_cyc = a_cyc;
    if (a_ssel && !a_ssel_prev && a_rise_cyc < 0) a_rise_cyc = a_cyc;
    if (!a_ssel) a_low++;
    if (a_rx_we) begin a_wr_addr.push_back(int'(a_rx_addr)); a_wr_data.push_back(a_rx_data); end
    if (a_tx_finish) a_txf++;
    if (a_rx_finish) a_rxf++;
    if (a_frame_done) begin a_fd++; if (a_done_cyc < 0) a_done_cyc = a_cyc; end
    a_sck_prev = a_sck; a_ssel_prev = a_ssel;
  endtask

  task automatic a_watch(input int tail, output bit timeout);
    int n;
    n = 0; timeout = 0;
    while (a_done_cyc < 0) begin
      a_step(); n++;
      if (n > 2000) begin timeout = 1; break; end
    end
    repeat (tail) a_step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({a_ssel, a_sck, a_mosi, a_rx_we, a_tx_finish, a_rx_finish, a_busy, a_frame_done} !== 8'b1000_0000)
      $display("[TB] FAIL reset_ctl: got %b expected 10000000",
               {a_ssel, a_sck, a_mosi, a_rx_we, a_tx_finish, a_rx_finish, a_busy, a_frame_done});
    else passed++;
    total++;
    if ({a_tx_addr, a_rx_addr, a_rx_data} !== '0)
      $display("[TB] FAIL reset_addr: got tx %0d rx %0d data %h expected 0 0 00", a_tx_addr, a_rx_addr, a_rx_data);
    else passed++;
    total++;
    if ({b_ssel, b_sck, b_busy} !== 3'b100)
      $display("[TB] FAIL reset_b: got %b expected 100", {b_ssel, b_sck, b_busy});
    else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_gating();
    int bad;
    bit to;
    a_loop = 1'b1;
    for (int i = 0; i < LEN_A; i++) a_mem[i] = 8'($urandom);
    a_drdy = 1'b1; a_rx_ready = 1'b1; a_tx_ready = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_ssel !== 1'b1 || a_busy !== 1'b0) bad++;
    end
    total++;
    if (bad !== 0) $display("[TB] FAIL gate_hold: got %0d bad cycles expected 0", bad);
    else passed++;
    a_clear();
    a_tx_ready = 1'b1;
    a_step();
    total++;
    if (a_busy !== 1'b1) $display("[TB] FAIL gate_busy: got %b expected 1", a_busy);
    else passed++;
    a_ready(1'b0);
    a_watch(2, to);
    total++;
    if (to) $display("[TB] FAIL gate_timeout: got timeout expected frame_done");
    else passed++;
    total++;
    if (a_fall_cyc !== 1) $display("[TB] FAIL gate_ssel: got %0d expected 1", a_fall_cyc);
    else passed++;
    total++;
    if (a_first_rise !== 3 + DIV_A) $display("[TB] FAIL gate_first_sck: got %0d expected %0d", a_first_rise, 3 + DIV_A);
    else passed++;
    total++;
    if (a_wr_addr.size() !== LEN_A) $display("[TB] FAIL gate_nwr: got %0d expected %0d", a_wr_addr.size(), LEN_A);
    else passed++;
    for (int i = 0; i < a_wr_addr.size() && i < LEN_A; i++) begin
      total++;
      if (a_wr_addr[i] !== i || a_wr_data[i] !== a_mem[i])
        $display("[TB] FAIL gate_wr%0d: got %0d:%h expected %0d:%h", i, a_wr_addr[i], a_wr_data[i], i, a_mem[i]);
      else passed++;
    end
  endtask

  task automatic test_loopback();
    bit to;
    int exp_low;
    a_loop = 1'b1;
    a_mem[0] = 8'hA5; a_mem[1] = 8'h3C; a_mem[2] = 8'hFF; a_mem[3] = 8'h00;
    exp_low = LEN_A * (16*DIV_A + 3) + DIV_A;
    a_clear();
    a_ready(1'b1);
    a_step();
    a_ready(1'b0);
    a_watch(4, to);
    total++;
    if (to) $display("[TB] FAIL loop_timeout: got timeout expected frame_done");
    else passed++;
    total++;
    if (a_rises !== 8*LEN_A) $display("[TB] FAIL loop_rises: got %0d expected %0d", a_rises, 8*LEN_A);
    else passed++;
    total++;
    if ({a_txf, a_rxf, a_fd} !== {32'd1, 32'd1, 32'd1})
      $display("[TB] FAIL loop_pulses: got %0d %0d %0d expected 1 1 1", a_txf, a_rxf, a_fd);
    else passed++;
    total++;
    if (a_low !== exp_low) $display("[TB] FAIL loop_ssel_low: got %0d expected %0d", a_low, exp_low);
    else passed++;
    total++;
    if (a_rise_cyc !== a_done_cyc) $display("[TB] FAIL loop_done_align: got %0d expected %0d", a_done_cyc, a_rise_cyc);
    else passed++;
    total++;
    if (a_busy !== 1'b0) $display("[TB] FAIL loop_busy_end: got %b expected 0", a_busy);
    else passed++;
    total++;
    if (a_wr_addr.size() !== LEN_A) $display("[TB] FAIL loop_nwr: got %0d expected %0d", a_wr_addr.size(), LEN_A);
    else passed++;
    for (int i = 0; i < a_wr_addr.size() && i < LEN_A; i++) begin
      total++;
      if (a_wr_addr[i] !== i || a_wr_data[i] !== a_mem[i])
        $display("[TB] FAIL loop_wr%0d: got %0d:%h expected %0d:%h", i, a_wr_addr[i], a_wr_data[i], i, a_mem[i]);
      else passed++;
    end
  endtask

  task automatic test_miso_order();
    bit to;
    a_loop = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < LEN_A; i++) begin
        a_pat[i] = 8'($urandom);
        a_mem[i] = 8'($urandom);
      end
      if (f == 0) begin a_pat[0] = 8'h81; a_pat[1] = 8'h00; end
      a_clear();
      a_ready(1'b1);
      a_step();
      a_ready(1'b0);
      a_watch(2, to);
      total++;
      if (to || a_wr_addr.size() !== LEN_A)
        $display("[TB] FAIL miso_nwr%0d: got %0d expected %0d", f, a_wr_addr.size(), LEN_A);
      else passed++;
      for (int i = 0; i < a_wr_addr.size() && i < LEN_A; i++) begin
        total++;
        if (a_wr_addr[i] !== i || a_wr_data[i] !== a_pat[i])
          $display("[TB] FAIL miso_f%0d_wr%0d: got %0d:%h expected %0d:%h", f, i, a_wr_addr[i], a_wr_data[i], i, a_pat[i]);
        else passed++;
      end
    end
    a_loop = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    int n;
    bit to;
    a_loop = 1'b1;
    for (int i = 0; i < LEN_A; i++) a_mem[i] = 8'($urandom);
    a_clear();
    a_ready(1'b1);
    a_step();
    a_ready(1'b0);
    n = 0;
    while (a_wr_addr.size() < 2 && n < 500) begin a_step(); n++; end
    total++;
    if (a_wr_addr.size() !== 2) $display("[TB] FAIL rstmid_reach: got %0d writes expected 2", a_wr_addr.size());
    else passed++;
    rst = 1'b1;
    a_step();
    total++;
    if ({a_ssel, a_sck, a_busy} !== 3'b100) $display("[TB] FAIL rstmid_idle: got %b expected 100", {a_ssel, a_sck, a_busy});
    else passed++;
    rst = 1'b0;
    repeat (40) a_step();
    total++;
    if (a_wr_addr.size() !== 2 || (a_txf + a_rxf + a_fd) !== 0)
      $display("[TB] FAIL rstmid_quiet: got %0d writes %0d pulses expected 2 0", a_wr_addr.size(), a_txf + a_rxf + a_fd);
    else passed++;
    for (int i = 0; i < LEN_A; i++) a_mem[i] = 8'($urandom);
    a_clear();
    a_ready(1'b1);
    a_step();
    a_ready(1'b0);
    a_watch(2, to);
    total++;
    if (to || a_wr_addr.size() !== LEN_A) $display("[TB] FAIL rstmid_nwr: got %0d expected %0d", a_wr_addr.size(), LEN_A);
    else passed++;
    for (int i = 0; i < a_wr_addr.size() && i < LEN_A; i++) begin
      total++;
      if (a_wr_addr[i] !== i || a_wr_data[i] !== a_mem[i])
        $display("[TB] FAIL rstmid_wr%0d: got %0d:%h expected %0d:%h", i, a_wr_addr[i], a_wr_data[i], i, a_mem[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit to;
    a_loop = 1'b1;
    for (int i = 0; i < LEN_A; i++) a_mem[i] = 8'($urandom);
    a_clear();
    a_ready(1'b1);
    a_watch(0, to);
    total++;
    if (to || a_wr_addr.size() !== LEN_A) $display("[TB] FAIL b2b_nwr1: got %0d expected %0d", a_wr_addr.size(), LEN_A);
    else passed++;
    for (int i = 0; i < a_wr_addr.size() && i < LEN_A; i++) begin
      total++;
      if (a_wr_addr[i] !== i || a_wr_data[i] !== a_mem[i])
        $display("[TB] FAIL b2b_f1_wr%0d: got %0d:%h expected %0d:%h", i, a_wr_addr[i], a_wr_data[i], i, a_mem[i]);
      else passed++;
    end
    n = 0;
    while (a_ssel && n < 10) begin a_step(); n++; end
    total++;
    if (n !== 3) $display("[TB] FAIL b2b_gap: got %0d expected 3", n);
    else passed++;
    total++;
    if (a_tx_addr !== '0) $display("[TB] FAIL b2b_tx_addr: got %0d expected 0", a_tx_addr);
    else passed++;
    for (int i = 0; i < LEN_A; i++) a_mem[i] = 8'($urandom);
    a_clear();
    a_watch(0, to);
    a_ready(1'b0);
    repeat (4) a_step();
    total++;
    if (to || a_wr_addr.size() !== LEN_A) $display("[TB] FAIL b2b_nwr2: got %0d expected %0d", a_wr_addr.size(), LEN_A);
    else passed++;
    for (int i = 0; i < a_wr_addr.size() && i < LEN_A; i++) begin
      total++;
      if (a_wr_addr[i] !== i || a_wr_data[i] !== a_mem[i])
        $display("[TB] FAIL b2b_f2_wr%0d: got %0d:%h expected %0d:%h", i, a_wr_addr[i], a_wr_data[i], i, a_mem[i]);
      else passed++;
    end
  endtask

  task automatic test_sck_timing();
    int   n, hi_run, lo_run, hi_bad, lo_bad, gaps, gap_bad, mosi_bad, rises, low, wr_i, wr_bad, exp_low;
    logic sp, mp;
    bit   to;
    for (int i = 0; i < LEN_B; i++) b_mem[i] = 8'($urandom);
    n = 0; hi_run = 0; lo_run = 0; hi_bad = 0; lo_bad = 0; gaps = 0; gap_bad = 0;
    mosi_bad = 0; rises = 0; low = 0; wr_i = 0; wr_bad = 0; to = 1'b0;
    exp_low = LEN_B * (16*DIV_B + 3) + DIV_B;
    sp = b_sck; mp = b_mosi;
    b_go = 1'b1;
    while (1) begin
      @(negedge clk);
      n++;
      if (n == 1) b_go = 1'b0;
      if (!b_ssel) low++;
      if (b_mosi !== mp && b_sck) mosi_bad++;
      if (b_sck) begin
        if (!sp) begin
          rises++;
          if (rises > 1) begin
            if ((rises - 1) % 8 == 0) begin
              gaps++;
              if (lo_run != DIV_B + 3) gap_bad++;
            end else if (lo_run != DIV_B) lo_bad++;
          end
          lo_run = 0;
        end
        hi_run++;
      end else begin
        if (sp) begin
          if (hi_run != DIV_B) hi_bad++;
          hi_run = 0;
        end
        lo_run++;
      end
      if (b_rx_we) begin
        if (wr_i >= LEN_B || int'(b_rx_addr) !== wr_i || b_rx_data !== b_mem[wr_i]) wr_bad++;
        wr_i++;
      end
      sp = b_sck; mp = b_mosi;
      if (b_frame_done) break;
      if (n > 3000) begin to = 1'b1; break; end
    end
    total++;
    if (to) $display("[TB] FAIL sck_timeout: got timeout expected frame_done");
    else passed++;
    total++;
    if (hi_bad !== 0) $display("[TB] FAIL sck_high_phase: got %0d bad expected 0", hi_bad);
    else passed++;
    total++;
    if (lo_bad !== 0) $display("[TB] FAIL sck_low_phase: got %0d bad expected 0", lo_bad);
    else passed++;
    total++;
    if (gap_bad !== 0 || gaps !== LEN_B - 1)
      $display("[TB] FAIL sck_gap: got %0d gaps %0d bad expected %0d gaps 0 bad", gaps, gap_bad, LEN_B - 1);
    else passed++;
    total++;
    if (mosi_bad !== 0) $display("[TB] FAIL mosi_stable: got %0d changes with sck high expected 0", mosi_bad);
    else passed++;
    total++;
    if (rises !== 8*LEN_B) $display("[TB] FAIL sck_rises_b: got %0d expected %0d", rises, 8*LEN_B);
    else passed++;
    total++;
    if (wr_i !== LEN_B || wr_bad !== 0)
      $display("[TB] FAIL loop_b_data: got %0d writes %0d bad expected %0d 0", wr_i, wr_bad, LEN_B);
    else passed++;
    total++;
    if (low !== exp_low) $display("[TB] FAIL ssel_low_b: got %0d expected %0d", low, exp_low);
    else passed++;
  endtask

  // Stimulus sequence and summary
  initial begin
    rst = 1'b1;
    a_ready(1'b0);
    a_loop = 1'b1;
    a_miso_drv = 1'b0;
    b_go = 1'b0;
    for (int i = 0; i < (1<<AW_A); i++) a_mem[i] = 8'h00;
    for (int i = 0; i < (1<<AW_B); i++) b_mem[i] = 8'h00;
    for (int i = 0; i < LEN_A; i++) a_pat[i] = 8'h00;
    test_reset();
    test_start_gating();
    test_loopback();
    test_miso_order();
    test_reset_mid_frame();
    test_back_to_back();
    test_sck_timing();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global time bound in case the sequence stalls
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
